// File: rtl/recirculation_mux_tx.sv
// recirculation_mux_tx
//   Domain-A launcher for the recirculation-mux CDC path. Accepts one word
//   from a valid/ready producer, holds it on o_data_A, fires a one-cycle
//   launch pulse and keeps the word frozen until the acknowledge toggle
//   from domain B has been synchronized back. A watchdog flags an
//   acknowledge that takes too long. An acknowledge edge that arrives while
//   idle is flagged as spurious.
//
// Ports
//   i_clk_A        domain-A clock (rising edge)
//   i_rst_A        asynchronous active-high reset, synchronous release
//   i_valid        upstream word valid
//   i_data         upstream word
//   o_ready        block can accept a word (state IDLE)
//   o_data_A       held word, to the receiver's i_data_A
//   o_pulse_A      one-cycle launch pulse, to the receiver's i_pulse_A
//   i_ack_toggle_B asynchronous ack level from domain B
//   o_busy         transfer in flight (state WAIT_ACK)
//   o_timeout      sticky watchdog flag, cleared by the next accept
//   o_spurious     one-cycle flag: ack edge seen while idle
module recirculation_mux_tx #(
  parameter int G_STAGES  = 2,
  parameter int G_WIDTH   = 4,
  parameter int G_TIMEOUT = 64
) (
  input  logic               i_clk_A,
  input  logic               i_rst_A,
  input  logic               i_valid,
  input  logic [G_WIDTH-1:0] i_data,
  output logic               o_ready,
  output logic [G_WIDTH-1:0] o_data_A,
  output logic               o_pulse_A,
  input  logic               i_ack_toggle_B,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_spurious
);

  // A zero-width counter is illegal, so keep one bit when the watchdog is off.
  localparam int CNT_W = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] T_MAX = G_TIMEOUT[CNT_W-1:0];

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [G_STAGES-1:0] ack_sync;
  logic                ack_prev;
  logic                ack_edge;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                timeout_nxt;

  // Ack toggle synchronizer and edge detector
  always_ff @(posedge i_clk_A or posedge i_rst_A) begin
    if (i_rst_A) begin
      ack_sync <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[G_STAGES-2:0], i_ack_toggle_B};
      ack_prev <= ack_sync[G_STAGES-1];
    end
  end

  assign ack_edge = ack_sync[G_STAGES-1] ^ ack_prev;
  assign o_ready  = (state == IDLE);
  assign o_busy   = (state == WAIT_ACK);
  assign accept   = i_valid && o_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_nxt = o_timeout;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = WAIT_ACK;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      WAIT_ACK: begin
        // An ack in the saturating cycle wins; the flag is then never set.
        if (ack_edge) begin
          state_nxt = IDLE;
        end else if ((G_TIMEOUT > 0) && (cnt != T_MAX)) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == T_MAX) begin
            timeout_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, launch pulse, flags and held word
  always_ff @(posedge i_clk_A or posedge i_rst_A) begin
    if (i_rst_A) begin
      state      <= IDLE;
      cnt        <= '0;
      o_timeout  <= 1'b0;
      o_pulse_A  <= 1'b0;
      o_spurious <= 1'b0;
      o_data_A   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_timeout  <= timeout_nxt;
      o_pulse_A  <= accept;
      o_spurious <= ack_edge && (state == IDLE);
      if (accept) begin
        o_data_A <= i_data;
      end
    end
  end

endmodule
